// File: rtl/calc_pkg.sv
// Shared calculator types: key codes, the BCD number format and the
// digit-entry state encoding.
package calc_pkg;

  localparam int NumDigits = 8;
  localparam int ExpWidth  = 8;

  typedef enum logic [3:0] {
    KEY_0     = 4'd0,
    KEY_1     = 4'd1,
    KEY_2     = 4'd2,
    KEY_3     = 4'd3,
    KEY_4     = 4'd4,
    KEY_5     = 4'd5,
    KEY_6     = 4'd6,
    KEY_7     = 4'd7,
    KEY_8     = 4'd8,
    KEY_9     = 4'd9,
    KEY_DOT   = 4'd10,
    KEY_CLEAR = 4'd11,
    KEY_BKSP  = 4'd12
  } key_t;

  // value = sum sig[i] * 10^(exponent - (NumDigits-1-i)), sig[NumDigits-1] is the MSD
  typedef struct packed {
    logic [NumDigits-1:0][3:0]   sig;
    logic signed [ExpWidth-1:0]  exponent;
  } num_t;

  typedef enum logic [1:0] {
    EMPTY,
    INT,
    FRAC,
    RESULT
  } entry_state_e;

  function automatic logic key_is_digit(input key_t k);
    return (k <= KEY_9);
  endfunction

endpackage

// File: rtl/digit_entry_if.sv
// Key handshake, ALU load path and display-facing outputs of digit_entry.
// slave is the digit_entry side, master is whoever drives keys and loads.
interface digit_entry_if;
  import calc_pkg::*;

  logic                         key_valid_i;
  key_t                         key_i;
  logic                         key_ready_o;
  logic                         load_i;
  num_t                         load_num_i;
  num_t                         num_o;
  logic                         entering_o;
  logic                         overflow_o;
  logic                         override_shift_amount_o;
  logic [$clog2(NumDigits)-1:0] new_shift_amount_o;

  modport slave (
    input  key_valid_i, key_i, load_i, load_num_i,
    output key_ready_o, num_o, entering_o, overflow_o,
           override_shift_amount_o, new_shift_amount_o
  );

  modport master (
    output key_valid_i, key_i, load_i, load_num_i,
    input  key_ready_o, num_o, entering_o, overflow_o,
           override_shift_amount_o, new_shift_amount_o
  );

endinterface

// File: rtl/digit_entry.sv
// Builds a left-aligned BCD number from keypad digits and '.', or holds an
// ALU result. The shift outputs let screen_driver show the entry right-aligned
// so typed trailing zeros and the decimal point stay visible.
// Optional feature: define DIGIT_ENTRY_BACKSPACE_EN to make KEY_BKSP undo the
// last digit or '.'; otherwise KEY_BKSP is accepted and ignored.
module digit_entry #(
  parameter int NumDigits = calc_pkg::NumDigits
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  digit_entry_if.slave   bus
);
  import calc_pkg::*;

  localparam int CntW = $clog2(NumDigits + 1);
  localparam int ShW  = $clog2(NumDigits);

  entry_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] frac_q, frac_d;
  num_t           num_q, num_d;
  logic           ovf_q, ovf_d;
  logic           entering_q, entering_d;
  logic           override_q, override_d;
  logic [ShW-1:0] shift_q, shift_d;
  logic [3:0]     key_digit;
  logic           full;

  assign key_digit = bus.key_i;
  assign full      = (int'(cnt_q) >= NumDigits);

  // Returns sig with the digit at position pos replaced by d.
  function automatic logic [NumDigits-1:0][3:0] set_digit(
    input logic [NumDigits-1:0][3:0] sig,
    input int                        pos,
    input logic [3:0]                d
  );
    logic [NumDigits-1:0][3:0] res;
    res = sig;
    for (int i = 0; i < NumDigits; i++) begin
      if (i == pos) res[i] = d;
    end
    return res;
  endfunction

  // Next state, counters, digit register and registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frac_d  = frac_q;
    num_d   = num_q;
    ovf_d   = 1'b0;

    if (bus.load_i) begin
      num_d   = bus.load_num_i;
      state_d = RESULT;
      cnt_d   = '0;
      frac_d  = '0;
    end else if (bus.key_valid_i) begin
      if (bus.key_i == KEY_CLEAR) begin
        state_d = EMPTY;
        num_d   = '0;
        cnt_d   = '0;
        frac_d  = '0;
      end else if (key_is_digit(bus.key_i)) begin
        if (state_q == EMPTY || state_q == RESULT) begin
          num_d  = '0;
          frac_d = '0;
          if (key_digit == 4'd0) begin
            state_d = EMPTY;
            cnt_d   = '0;
          end else begin
            num_d.sig[NumDigits-1] = key_digit;
            cnt_d   = CntW'(1);
            state_d = INT;
          end
        end else if (full) begin
          ovf_d = 1'b1;
        end else begin
          num_d.sig = set_digit(num_q.sig, NumDigits - 1 - int'(cnt_q), key_digit);
          cnt_d     = cnt_q + CntW'(1);
          if (state_q == FRAC) frac_d = frac_q + CntW'(1);
        end
      end else if (bus.key_i == KEY_DOT) begin
        if (state_q == EMPTY || state_q == RESULT) begin
          num_d   = '0;
          cnt_d   = CntW'(1);
          frac_d  = '0;
          state_d = FRAC;
        end else if (state_q == INT) begin
          state_d = FRAC;
        end
`ifdef DIGIT_ENTRY_BACKSPACE_EN
      end else if (bus.key_i == KEY_BKSP) begin
        if (state_q == FRAC) begin
          if (frac_q != '0) begin
            num_d.sig = set_digit(num_q.sig, NumDigits - int'(cnt_q), 4'd0);
            cnt_d     = cnt_q - CntW'(1);
            frac_d    = frac_q - CntW'(1);
          end else begin
            state_d = INT;
          end
        end else if (state_q == INT) begin
          if (cnt_q == CntW'(1)) begin
            state_d = EMPTY;
            num_d   = '0;
            cnt_d   = '0;
            frac_d  = '0;
          end else begin
            num_d.sig = set_digit(num_q.sig, NumDigits - int'(cnt_q), 4'd0);
            cnt_d     = cnt_q - CntW'(1);
          end
        end
`endif
      end
    end

    entering_d = (state_d == INT) || (state_d == FRAC);
    if (!bus.load_i && entering_d) begin
      num_d.exponent = ExpWidth'(int'(cnt_d) - int'(frac_d) - 1);
    end
    override_d = entering_d;
    shift_d    = entering_d ? ShW'(NumDigits - int'(cnt_d)) : '0;
  end

  // Single state register for the FSM, counters, number and outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      cnt_q      <= '0;
      frac_q     <= '0;
      num_q      <= '0;
      ovf_q      <= 1'b0;
      entering_q <= 1'b0;
      override_q <= 1'b0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frac_q     <= frac_d;
      num_q      <= num_d;
      ovf_q      <= ovf_d;
      entering_q <= entering_d;
      override_q <= override_d;
      shift_q    <= shift_d;
    end
  end

  assign bus.key_ready_o             = !bus.load_i;
  assign bus.num_o                   = num_q;
  assign bus.entering_o              = entering_q;
  assign bus.overflow_o              = ovf_q;
  assign bus.override_shift_amount_o = override_q;
  assign bus.new_shift_amount_o      = shift_q;

endmodule

// File: tb/tb_digit_entry.sv
// Self-checking bench for digit_entry: directed cases followed by random key
// and load traffic, compared against a digit-list model of the entry rules.
module tb_digit_entry;
  import calc_pkg::*;

  localparam int N = NumDigits;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  digit_entry_if bus();

  digit_entry #(.NumDigits(N)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: typed digits as a list, plus '.' presence and digits after it.
  int   digs[$];
  bit   has_dot;
  int   frac_cnt;
  int   mode;          // 0 empty, 1 entering, 2 holding a result
  num_t result_val;
  bit   exp_ovf;

  task automatic model_reset();
    digs.delete();
    has_dot  = 1'b0;
    frac_cnt = 0;
    mode     = 0;
    result_val = '0;
    exp_ovf  = 1'b0;
  endtask

  task automatic model_step(input bit valid, input key_t key, input bit load, input num_t lnum);
    int k;
    k = int'(key);
    exp_ovf = 1'b0;
    if (load) begin
      mode = 2; result_val = lnum; digs.delete(); has_dot = 0; frac_cnt = 0;
    end else if (valid) begin
      if (key == KEY_CLEAR) begin
        mode = 0; digs.delete(); has_dot = 0; frac_cnt = 0;
      end else if (k <= 9) begin
        if (mode != 1) begin
          digs.delete(); has_dot = 0; frac_cnt = 0;
          if (k == 0) mode = 0;
          else begin mode = 1; digs.push_back(k); end
        end else if (digs.size() >= N) begin
          exp_ovf = 1'b1;
        end else begin
          digs.push_back(k);
          if (has_dot) frac_cnt++;
        end
      end else if (key == KEY_DOT) begin
        if (mode != 1) begin
          digs.delete(); digs.push_back(0); has_dot = 1; frac_cnt = 0; mode = 1;
        end else has_dot = 1;
      end else if (key == KEY_BKSP) begin
`ifdef DIGIT_ENTRY_BACKSPACE_EN
        if (mode == 1) begin
          if (has_dot && frac_cnt > 0) begin void'(digs.pop_back()); frac_cnt--; end
          else if (has_dot) has_dot = 0;
          else if (digs.size() == 1) begin mode = 0; digs.delete(); end
          else void'(digs.pop_back());
        end
`endif
      end
    end
  endtask

  function automatic num_t model_num();
    num_t e;
    e = '0;
    if (mode == 2) return result_val;
    if (mode == 1) begin
      for (int i = 0; i < digs.size(); i++) e.sig[N-1-i] = 4'(digs[i]);
      e.exponent = 8'(digs.size() - frac_cnt - 1);
    end
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_output();
    check_val("num_o", bus.num_o, model_num());
    check_val("entering_o", bus.entering_o, (mode == 1));
    check_val("overflow_o", bus.overflow_o, exp_ovf);
    check_val("override", bus.override_shift_amount_o, (mode == 1));
    check_val("shift", bus.new_shift_amount_o, (mode == 1) ? 64'(N - digs.size()) : 64'd0);
  endtask

  task automatic apply_stimulus(input bit valid, input key_t key, input bit load, input num_t lnum);
    bus.key_valid_i = valid;
    bus.key_i       = key;
    bus.load_i      = load;
    bus.load_num_i  = lnum;
    #1;
    check_val("key_ready_o", bus.key_ready_o, !load);
    @(posedge clk);
    model_step(valid, key, load, lnum);
    #1;
    bus.key_valid_i = 1'b0;
    bus.load_i      = 1'b0;
    check_output();
  endtask

  task automatic press(input key_t key);
    apply_stimulus(1'b1, key, 1'b0, '0);
  endtask

  task automatic idle();
    apply_stimulus(1'b0, KEY_0, 1'b0, '0);
  endtask

  function automatic num_t random_num();
    num_t r;
    for (int i = 0; i < N; i++) r.sig[i] = 4'($urandom_range(0, 9));
    r.exponent = 8'($urandom_range(0, 255));
    return r;
  endfunction

  initial begin
    num_t lv;
    int   r;
    int   k;

    bus.key_valid_i = 1'b0;
    bus.key_i       = KEY_0;
    bus.load_i      = 1'b0;
    bus.load_num_i  = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_output();
    check_val("reset_ready", bus.key_ready_o, 1'b1);
    rst_n = 1'b1;

    $display("[TB] keys 1,2,3");
    press(KEY_1); press(KEY_2); press(KEY_3);
    check_val("sig_top3", {bus.num_o.sig[7], bus.num_o.sig[6], bus.num_o.sig[5]}, 12'h123);
    check_val("exp_123", bus.num_o.exponent, 8'd2);
    check_val("shift_123", bus.new_shift_amount_o, 3'd5);

    $display("[TB] reset asserted mid-entry");
    rst_n = 1'b0;
    #2;
    model_reset();
    check_output();
    #1;
    rst_n = 1'b1;

    $display("[TB] keys 0,DOT,5 then DOT");
    press(KEY_0); press(KEY_DOT); press(KEY_5);
    check_val("shift_0p5", bus.new_shift_amount_o, 3'd6);
    press(KEY_DOT);

    $display("[TB] nine 9s");
    press(KEY_CLEAR);
    repeat (9) press(KEY_9);
    check_val("ovf_pulse", bus.overflow_o, 1'b1);
    idle();
    press(KEY_DOT);
    press(KEY_3);
    idle();

    $display("[TB] load with key 4, then key 7");
    lv = random_num();
    apply_stimulus(1'b1, KEY_4, 1'b1, lv);
    press(KEY_7);
    check_val("sig_after_load", bus.num_o.sig[7], 4'd7);

    $display("[TB] backspace sequence");
    press(KEY_CLEAR);
    press(KEY_1); press(KEY_DOT); press(KEY_2); press(KEY_BKSP); press(KEY_BKSP);
`ifdef DIGIT_ENTRY_BACKSPACE_EN
    check_val("bksp_shift", bus.new_shift_amount_o, 3'd7);
`else
    check_val("bksp_shift", bus.new_shift_amount_o, 3'd6);
`endif
    press(KEY_CLEAR);
    press(KEY_BKSP);

    $display("[TB] random traffic");
    for (int step = 0; step < 500; step++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        apply_stimulus(1'($urandom_range(0, 1)), key_t'(4'($urandom_range(0, 12))), 1'b1, random_num());
      end else if (r < 15) begin
        idle();
      end else begin
        k = $urandom_range(0, 15);
        if (k == 13) k = 12;
        else if (k == 14) k = 10;
        else if (k == 15) k = $urandom_range(0, 9);
        press(key_t'(4'(k)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
